// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundle between two write requesters, the clear requester and the
// register-file write port driven by regfile_write_arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              REQ0;
  logic [ADDR_W-1:0] REQ0_ADDR;
  logic [DATA_W-1:0] REQ0_DATA;
  logic              GNT0;
  logic              REQ1;
  logic [ADDR_W-1:0] REQ1_ADDR;
  logic [DATA_W-1:0] REQ1_DATA;
  logic              GNT1;
  logic              CLEAR_REQ;
  logic              CLEAR_BUSY;
  logic              WRITE;
  logic [ADDR_W-1:0] INADDRESS;
  logic [DATA_W-1:0] IN;

  modport master (
    output REQ0, REQ0_ADDR, REQ0_DATA,
    output REQ1, REQ1_ADDR, REQ1_DATA,
    output CLEAR_REQ,
    input  GNT0, GNT1, CLEAR_BUSY, WRITE, INADDRESS, IN
  );

  modport slave (
    input  REQ0, REQ0_ADDR, REQ0_DATA,
    input  REQ1, REQ1_ADDR, REQ1_DATA,
    input  CLEAR_REQ,
    output GNT0, GNT1, CLEAR_BUSY, WRITE, INADDRESS, IN
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for two register-file writers plus a clear sequencer
// that zeroes registers 0..NREGS-1. Every output is registered.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NREGS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
  logic              rr_favour1, rr_favour1_nx;

  logic              gnt0_q, gnt1_q, busy_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              gnt0_nx, gnt1_nx, busy_nx, write_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;

  logic              elig0, elig1;
  logic              pick0, pick1, start_clr;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      rr_favour1 <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      rr_favour1 <= rr_favour1_nx;
      gnt0_q     <= gnt0_nx;
      gnt1_q     <= gnt1_nx;
      busy_q     <= busy_nx;
      write_q    <= write_nx;
      addr_q     <= addr_nx;
      data_q     <= data_nx;
    end
  end

  // A request seen while its own grant is still showing was already served.
  assign elig0 = bus.REQ0 & ~gnt0_q;
  assign elig1 = bus.REQ1 & ~gnt1_q;

  // Next-state and arbitration decision
  always_comb begin
    state_nx      = state;
    clr_cnt_nx    = clr_cnt;
    rr_favour1_nx = rr_favour1;
    pick0         = 1'b0;
    pick1         = 1'b0;
    start_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLEAR_REQ) begin
          // Address 0 is written on the entry edge; CLEAR covers 1..NREGS-1.
          start_clr = 1'b1;
          if (NREGS > 1) begin
            state_nx   = CLEAR;
            clr_cnt_nx = ADDR_W'(1);
          end
        end else if (elig0 && elig1) begin
          pick0         = ~rr_favour1;
          pick1         = rr_favour1;
          rr_favour1_nx = ~rr_favour1;
        end else if (elig0) begin
          pick0         = 1'b1;
          rr_favour1_nx = 1'b1;
        end else if (elig1) begin
          pick1         = 1'b1;
          rr_favour1_nx = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nx = IDLE;
        end else begin
          clr_cnt_nx = clr_cnt + ADDR_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Values loaded into the output registers at the coming edge
  always_comb begin
    gnt0_nx  = 1'b0;
    gnt1_nx  = 1'b0;
    busy_nx  = 1'b0;
    write_nx = 1'b0;
    addr_nx  = '0;
    data_nx  = '0;
    if (state == CLEAR) begin
      busy_nx  = 1'b1;
      write_nx = 1'b1;
      addr_nx  = clr_cnt;
    end else if (start_clr) begin
      busy_nx  = 1'b1;
      write_nx = 1'b1;
    end else if (pick0) begin
      gnt0_nx  = 1'b1;
      write_nx = 1'b1;
      addr_nx  = bus.REQ0_ADDR;
      data_nx  = bus.REQ0_DATA;
    end else if (pick1) begin
      gnt1_nx  = 1'b1;
      write_nx = 1'b1;
      addr_nx  = bus.REQ1_ADDR;
      data_nx  = bus.REQ1_DATA;
    end
  end

  assign bus.GNT0       = gnt0_q;
  assign bus.GNT1       = gnt1_q;
  assign bus.CLEAR_BUSY = busy_q;
  assign bus.WRITE      = write_q;
  assign bus.INADDRESS  = addr_q;
  assign bus.IN         = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  logic CLK = 1'b0;
  logic RESET;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       r0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       clr;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Output vector layout: {GNT0, GNT1, CLEAR_BUSY, WRITE, INADDRESS, IN}
  function automatic logic [14:0] mk(logic g0, logic g1, logic b, logic w,
                                     logic [2:0] a, logic [7:0] d);
    return {g0, g1, b, w, a, d};
  endfunction

  function automatic logic [14:0] outv();
    return {bus.GNT0, bus.GNT1, bus.CLEAR_BUSY, bus.WRITE, bus.INADDRESS, bus.IN};
  endfunction

  task automatic chk(string name, logic [14:0] act, logic [14:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {g0,g1,busy,wr,addr,data}=%b_%b_%b_%b_%0d_%02h required %b_%b_%b_%b_%0d_%02h",
               name, act[14], act[13], act[12], act[11], act[10:8], act[7:0],
               req[14], req[13], req[12], req[11], req[10:8], req[7:0]);
    end
  endtask

  task automatic idle_inputs();
    bus.REQ0 = 1'b0; bus.REQ0_ADDR = '0; bus.REQ0_DATA = '0;
    bus.REQ1 = 1'b0; bus.REQ1_ADDR = '0; bus.REQ1_DATA = '0;
    bus.CLEAR_REQ = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(string name);
    RESET = 1'b0;
    idle_inputs();
    #1 chk(name, outv(), '0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Reference model: pending clear addresses as a queue, round-robin as "who won last".
  int          last_gnt;
  int unsigned clr_q[$];
  logic [14:0] exp_v;

  task automatic model_reset();
    last_gnt = -1;
    clr_q.delete();
    exp_v = '0;
  endtask

  task automatic model_step();
    logic g0, g1, b, w;
    logic [2:0] a;
    logic [7:0] d;
    bit e0, e1;
    int who;
    g0 = 0; g1 = 0; b = 0; w = 0; a = '0; d = '0; who = -1;
    if (clr_q.size() != 0) begin
      a = 3'(clr_q.pop_front());
      w = 1; b = 1;
    end else if (bus.CLEAR_REQ) begin
      for (int i = 1; i < NREGS; i++) clr_q.push_back(i);
      w = 1; b = 1;
    end else begin
      e0 = bus.REQ0 && !exp_v[14];
      e1 = bus.REQ1 && !exp_v[13];
      if (e0 && e1) who = (last_gnt == 0) ? 1 : 0;
      else if (e0)  who = 0;
      else if (e1)  who = 1;
      if (who == 0) begin g0 = 1; w = 1; a = bus.REQ0_ADDR; d = bus.REQ0_DATA; end
      if (who == 1) begin g1 = 1; w = 1; a = bus.REQ1_ADDR; d = bus.REQ1_DATA; end
      if (who >= 0) last_gnt = who;
    end
    exp_v = mk(g0, g1, b, w, a, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    idle_inputs();
    @(negedge CLK);

    // ---------------- vector table ----------------
    tbl.push_back('{1, 3'd2, 8'h1F, 0, 3'd0, 8'h00, 0, mk(1,0,0,1,3'd2,8'h1F)});
    tbl.push_back('{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, mk(0,0,0,0,3'd0,8'h00)});
    tbl.push_back('{1, 3'd1, 8'hAA, 1, 3'd4, 8'h55, 0, mk(0,1,0,1,3'd4,8'h55)});
    tbl.push_back('{1, 3'd1, 8'hAA, 1, 3'd4, 8'h55, 0, mk(1,0,0,1,3'd1,8'hAA)});
    tbl.push_back('{1, 3'd1, 8'hAA, 1, 3'd4, 8'h55, 0, mk(0,1,0,1,3'd4,8'h55)});
    tbl.push_back('{1, 3'd1, 8'hAA, 1, 3'd4, 8'h55, 0, mk(1,0,0,1,3'd1,8'hAA)});
    tbl.push_back('{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, mk(0,0,0,0,3'd0,8'h00)});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 3'd7, 8'h3C, 0, mk(0,1,0,1,3'd7,8'h3C)});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 3'd7, 8'h3C, 0, mk(0,0,0,0,3'd0,8'h00)});
    tbl.push_back('{0, 3'd0, 8'h00, 1, 3'd7, 8'h3C, 0, mk(0,1,0,1,3'd7,8'h3C)});
    tbl.push_back('{1, 3'd5, 8'h11, 1, 3'd5, 8'h22, 0, mk(1,0,0,1,3'd5,8'h11)});
    tbl.push_back('{1, 3'd5, 8'h11, 1, 3'd5, 8'h22, 0, mk(0,1,0,1,3'd5,8'h22)});
    tbl.push_back('{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, mk(0,0,0,0,3'd0,8'h00)});
    tbl.push_back('{1, 3'd6, 8'h99, 0, 3'd0, 8'h00, 1, mk(0,0,1,1,3'd0,8'h00)});
    for (int i = 1; i < NREGS; i++)
      tbl.push_back('{1, 3'd6, 8'h99, 0, 3'd0, 8'h00, 0, mk(0,0,1,1,3'(i),8'h00)});
    tbl.push_back('{1, 3'd6, 8'h99, 0, 3'd0, 8'h00, 0, mk(1,0,0,1,3'd6,8'h99)});
    tbl.push_back('{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, mk(0,0,0,0,3'd0,8'h00)});

    do_reset("reset_state");
    foreach (tbl[i]) begin
      bus.REQ0 = tbl[i].r0; bus.REQ0_ADDR = tbl[i].a0; bus.REQ0_DATA = tbl[i].d0;
      bus.REQ1 = tbl[i].r1; bus.REQ1_ADDR = tbl[i].a1; bus.REQ1_DATA = tbl[i].d1;
      bus.CLEAR_REQ = tbl[i].clr;
      cyc();
      chk($sformatf("vec%0d", i), outv(), tbl[i].exp);
    end

    // ---------------- contention held from reset release ----------------
    RESET = 1'b0;
    idle_inputs();
    bus.REQ0 = 1; bus.REQ0_ADDR = 3'd1; bus.REQ0_DATA = 8'hAA;
    bus.REQ1 = 1; bus.REQ1_ADDR = 3'd4; bus.REQ1_DATA = 8'h55;
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("contend%0d", i), outv(),
          (i % 2 == 0) ? mk(1,0,0,1,3'd1,8'hAA) : mk(0,1,0,1,3'd4,8'h55));
    end

    // ---------------- clear with REQ1 raised mid-sequence ----------------
    do_reset("reset_before_clear");
    bus.CLEAR_REQ = 1;
    for (int i = 0; i < NREGS; i++) begin
      cyc();
      if (i == 0) bus.CLEAR_REQ = 0;
      chk($sformatf("clear%0d", i), outv(), mk(0,0,1,1,3'(i),8'h00));
      if (i == 2) begin bus.REQ1 = 1; bus.REQ1_ADDR = 3'd6; bus.REQ1_DATA = 8'h77; end
    end
    cyc();
    chk("clear_then_gnt1", outv(), mk(0,1,0,1,3'd6,8'h77));
    bus.REQ1 = 0;
    cyc();
    chk("clear_then_idle", outv(), '0);

    // ---------------- CLEAR_REQ beats REQ0 at the same edge ----------------
    do_reset("reset_before_prio");
    bus.CLEAR_REQ = 1;
    bus.REQ0 = 1; bus.REQ0_ADDR = 3'd3; bus.REQ0_DATA = 8'h42;
    for (int i = 0; i < NREGS; i++) begin
      cyc();
      if (i == 0) bus.CLEAR_REQ = 0;
      chk($sformatf("prio_clear%0d", i), outv(), mk(0,0,1,1,3'(i),8'h00));
    end
    cyc();
    chk("prio_gnt0", outv(), mk(1,0,0,1,3'd3,8'h42));
    bus.REQ0 = 0;

    // ---------------- reset during clear ----------------
    do_reset("reset_before_abort");
    bus.CLEAR_REQ = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) bus.CLEAR_REQ = 0;
      chk($sformatf("abort_clear%0d", i), outv(), mk(0,0,1,1,3'(i),8'h00));
    end
    #2 RESET = 1'b0;
    #1 chk("abort_async", outv(), '0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("abort_after%0d", i), outv(), '0);
    end

    // ---------------- same requester back to back ----------------
    do_reset("reset_before_b2b");
    bus.REQ0 = 1; bus.REQ0_ADDR = 3'd3; bus.REQ0_DATA = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("b2b%0d", i), outv(), (i % 2 == 0) ? mk(1,0,0,1,3'd3,8'h5A) : '0);
    end

    // ---------------- random traffic vs reference model ----------------
    do_reset("reset_before_rand");
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      chk($sformatf("rand%0d", n), outv(), exp_v);
      // A requester holds its request until it sees its grant.
      if (!bus.REQ0 || exp_v[14]) begin
        bus.REQ0 = ($urandom_range(0, 2) != 0);
        bus.REQ0_ADDR = 3'($urandom_range(0, 7));
        bus.REQ0_DATA = 8'($urandom_range(0, 255));
      end
      if (!bus.REQ1 || exp_v[13]) begin
        bus.REQ1 = ($urandom_range(0, 2) != 0);
        bus.REQ1_ADDR = 3'($urandom_range(0, 7));
        bus.REQ1_DATA = 8'($urandom_range(0, 255));
      end
      if (bus.CLEAR_REQ) bus.CLEAR_REQ = ($urandom_range(0, 3) != 0);
      else               bus.CLEAR_REQ = ($urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be as follows: DATA_W, 8, register data width; ADDR_W, 3, register address width; NREGS, 8, number of registers cleared by the clear sequence.
REQ-002 CLK  in  1  single clock; all state SHALL change on rising edge only.
REQ-003 RESET  in  1  reset is asynchronous and active-low.
REQ-004 REQ0  in  1  requester 0 write request.
REQ-005 REQ0_ADDR  in  ADDR_W  requester 0 target register.
REQ-006 REQ0_DATA  in  DATA_W  requester 0 write data.
REQ-007 GNT0  out  1  requester 0 grant, one-cycle pulse.
REQ-008 REQ1, REQ1_ADDR, REQ1_DATA, GNT1 SHALL mirror REQ-004..007 for requester 1.
REQ-009 CLEAR_REQ  in  1  request to zero all NREGS registers.
REQ-010 CLEAR_BUSY  out  1  high while the clear sequence runs.
REQ-011 WRITE  out  1  register file write enable.
REQ-012 INADDRESS  out  ADDR_W  register file write address.
REQ-013 IN  out  DATA_W  register file write data.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 FSM states: IDLE (arbitrating) and CLEAR (sequencing); no other states.
REQ-016 In IDLE at rising edge k, if CLEAR_REQ=1, the FSM SHALL enter CLEAR; CLEAR takes priority over REQ0/REQ1 sampled at the same edge, and no grant is issued at edge k.
REQ-017 In IDLE at edge k, with CLEAR_REQ=0 and exactly one eligible request, that requester SHALL be granted.
REQ-018 With both requests eligible, the requester not granted most recently SHALL be granted (round-robin); after reset requester 0 wins first.
REQ-019 A grant at edge k SHALL register GNTx=1, WRITE=1, INADDRESS=REQx_ADDR, IN=REQx_DATA for exactly one cycle; the register file commits at edge k+1.
REQ-020 A request SHALL be eligible only when its GNT is 0 at the sampling edge; REQx sampled while GNTx=1 SHALL be ignored (one grant consumes one request).
REQ-021 Requesters SHALL hold REQ, ADDR, DATA stable until GNT is observed high; the arbiter SHALL never drop a pending request.
REQ-022 With both requesters continuously requesting, grants SHALL alternate 0,1,0,1 with WRITE=1 every cycle.
REQ-023 In any cycle with WRITE=0, INADDRESS and IN SHALL be 0.
REQ-024 CLEAR SHALL run exactly NREGS cycles: WRITE=1, IN=0, INADDRESS=0,1,...,NREGS-1 in increasing order, CLEAR_BUSY=1 throughout.
REQ-025 After the cycle with INADDRESS=NREGS-1 the FSM SHALL return to IDLE; CLEAR_BUSY and WRITE SHALL fall at the same edge unless a grant issues at that edge.
REQ-026 During CLEAR, GNT0/GNT1 SHALL stay 0, pending requests SHALL wait, and CLEAR_REQ SHALL be ignored; CLEAR_REQ still high on return to IDLE SHALL start a new clear.
REQ-027 The first IDLE edge after CLEAR SHALL arbitrate normally; round-robin state SHALL be unchanged by CLEAR.
REQ-028 Identical REQ0_ADDR and REQ1_ADDR SHALL cause no conflict; writes are serialized in grant order.

Reset
REQ-029 RESET=0 SHALL immediately force IDLE, GNT0=GNT1=0, WRITE=0, INADDRESS=0, IN=0, CLEAR_BUSY=0, round-robin favouring requester 0.
REQ-030 RESET asserted mid-CLEAR SHALL abort the sequence with no further writes; after release, IDLE with no clear pending.
REQ-031 The first rising edge after RESET release SHALL arbitrate normally.

Verification
REQ-032 Single request: REQ0=1, ADDR=3'b010, DATA=8'h1F before edge k -> at edge k GNT0=1, WRITE=1, INADDRESS=2, IN=8'h1F; edge k+1 all 0 if REQ0 dropped.
REQ-033 Contention: REQ0 (addr 1, 8'hAA) and REQ1 (addr 4, 8'h55) held high from reset release -> grants 0,1,0,1 on consecutive edges; INADDRESS 1,4,1,4.
REQ-034 Clear: CLEAR_REQ pulse in IDLE -> 8 cycles WRITE=1, IN=0, INADDRESS 0..7, CLEAR_BUSY=1; a REQ1 raised during cycle 3 is granted on the first edge after CLEAR_BUSY falls.
REQ-035 Priority: CLEAR_REQ=1 and REQ0=1 at the same edge -> CLEAR begins, GNT0=0 for 8 cycles, then GNT0=1.
REQ-036 Reset mid-clear: RESET=0 while INADDRESS=5 -> outputs 0 immediately; no writes to addresses 6, 7 after release.
REQ-037 Back-to-back same requester: REQ0 held high, REQ1=0 -> GNT0 pulses every other cycle (1,0,1,0), never two consecutive cycles.
